// File: rtl/booth_seq_mult_if.sv
// Handshake and operand/result bundle between a requester and the Booth multiplier core.
interface booth_seq_mult_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned PW = 2 * WIDTH;

    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [PW-1:0]    product;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  product,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output product,
        output busy,
        output done
    );
endinterface

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, signed operands,
// registered 2*WIDTH product with a one-cycle done strobe.
module booth_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    booth_seq_mult_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   a_q, a_nxt;
    logic [WIDTH:0]   m_q, m_nxt;
    logic [WIDTH-1:0] q_q, q_nxt;
    logic             qm1_q, qm1_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [PW-1:0]    prod_q, prod_nxt;
    logic             busy_q, done_q;
    logic [WIDTH:0]   sum_c;

    // State and datapath registers; busy/done are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            m_q    <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            cnt_q  <= '0;
            prod_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_q    <= a_nxt;
            m_q    <= m_nxt;
            q_q    <= q_nxt;
            qm1_q  <= qm1_nxt;
            cnt_q  <= cnt_nxt;
            prod_q <= prod_nxt;
            busy_q <= (state_nxt == CALC);
            done_q <= (state_nxt == DONE);
        end
    end

    // Next-state and Booth step logic.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        m_nxt     = m_q;
        q_nxt     = q_q;
        qm1_nxt   = qm1_q;
        cnt_nxt   = cnt_q;
        prod_nxt  = prod_q;
        sum_c     = a_q;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Guard bit on A and M keeps -2^(WIDTH-1) representable after negation.
                    m_nxt     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
                    q_nxt     = bus.multiplier;
                    a_nxt     = '0;
                    qm1_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = CALC;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                case ({q_q[0], qm1_q})
                    2'b01:   sum_c = a_q + m_q;
                    2'b10:   sum_c = a_q - m_q;
                    default: sum_c = a_q;
                endcase
                {a_nxt, q_nxt, qm1_nxt} = {sum_c[WIDTH], sum_c, q_q};
                cnt_nxt = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    prod_nxt  = {a_nxt[WIDTH-1:0], q_nxt};
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.product = prod_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult at WIDTH=8.
module tb_booth_seq_mult;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    booth_seq_mult_if #(.WIDTH(8)) bus ();

    booth_seq_mult #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse and wait (bounded) for done; leaves the bench in the done cycle.
    task automatic do_mult(input string tag, input logic [7:0] m, input logic [7:0] q,
                           input logic [15:0] exp, output logic [15:0] mid_prod);
        int n;
        int busy_n;
        n        = 0;
        busy_n   = 0;
        mid_prod = 'x;
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        do begin
            tick();
            n++;
            if (n == 1) bus.start = 1'b0;
            if (n == 4) mid_prod = bus.product;
            if (bus.busy) busy_n++;
        end while (!bus.done && n < 40);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_busy_cycles"}, busy_n, 8);
        chk({tag, "_product"}, 32'(bus.product), 32'(exp));
    endtask

    initial begin
        logic [15:0] mid;
        int n;
        int dcount;
        checks   = 0;
        failures = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        tick();
        tick();
        chk("reset_product", 32'(bus.product), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        tick();

        do_mult("m7_q3", 8'd7, 8'd3, 16'h0015, mid);
        tick();
        chk("m7_q3_done_one_cycle", 32'(bus.done), 32'd0);
        chk("m7_q3_hold", 32'(bus.product), 32'h0015);

        do_mult("mneg5_q6", 8'hFB, 8'd6, 16'hFFE2, mid);
        tick();
        do_mult("m6_qneg5", 8'd6, 8'hFB, 16'hFFE2, mid);
        tick();
        do_mult("mmin_qmin", 8'h80, 8'h80, 16'h4000, mid);
        tick();
        do_mult("mmin_qmax", 8'h80, 8'h7F, 16'hC080, mid);
        tick();
        do_mult("m0_qneg1", 8'h00, 8'hFF, 16'h0000, mid);
        tick();

        // Start during CALC and operand changes mid-calculation must be ignored.
        bus.multiplicand = 8'd10;
        bus.multiplier   = 8'd10;
        bus.start        = 1'b1;
        n = 0;
        tick(); n++;
        bus.start = 1'b0;
        tick(); n++;
        tick(); n++;
        bus.multiplicand = 8'd3;
        bus.multiplier   = 8'hFF;
        bus.start        = 1'b1;
        tick(); n++;
        bus.start        = 1'b0;
        bus.multiplicand = 8'd99;
        bus.multiplier   = 8'd55;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk("ignore_latency", n, 9);
        chk("ignore_product", 32'(bus.product), 32'h0064);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dcount++;
        end
        chk("ignore_single_done", dcount, 0);
        chk("ignore_idle_busy", 32'(bus.busy), 32'd0);

        // Back-to-back: second start lands in the DONE cycle of the first.
        do_mult("b2b_first", 8'd5, 8'd5, 16'h0019, mid);
        do_mult("b2b_second", 8'd2, 8'hFD, 16'hFFFA, mid);
        chk("b2b_product_held", 32'(mid), 32'h0019);
        tick();

        // Asynchronous reset mid-clock during step 4 aborts the operation.
        bus.multiplicand = 8'd7;
        bus.multiplier   = 8'd7;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_product", 32'(bus.product), 32'd0);
        tick();
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        do_mult("after_abort", 8'hF9, 8'd9, 16'hFFC1, mid);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
Sequential radix-2 Booth multiplier core for signed two's-complement operands, one Booth step per clock. It sits directly downstream of the rising-edge detector: that stage's one-cycle pulse drives `start`. The core latches the operands, iterates WIDTH steps, then presents a registered product with a one-cycle `done` strobe for display/readback logic.

Parameters:
- WIDTH, 8, operand width in bits (signed); WIDTH >= 2. Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state immediately.
- start  input  1  single-cycle start pulse (from edge detector); sampled on rising clk.
- multiplicand  input  WIDTH  signed operand M; sampled only when start is accepted.
- multiplier  input  WIDTH  signed operand Q; sampled only when start is accepted.
- product  output  2*WIDTH  signed result M*Q; registered, held until next completion.
- busy  output  1  high while iterating (state CALC).
- done  output  1  one-cycle strobe, high in the cycle the new product is valid.

Behaviour:
- Reset (async, rst=1): state=IDLE, product=0, busy=0, done=0, internal A/Q/Q-1/M/counter=0. Reset is effective immediately, independent of clk.
- Datapath registers:
  - A: WIDTH+1 bits, the guard bit that prevents overflow for M = -2^(WIDTH-1).
  - Qr: WIDTH bits.
  - q_m1: 1 bit.
  - Mr: WIDTH+1 bits, sign-extended M.
  - step counter: clog2(WIDTH)+1 bits.
- States: IDLE, CALC, DONE. busy = (state==CALC); done = (state==DONE).
- IDLE:
  - start=1 at edge E0: Mr<=sext(multiplicand), Qr<=multiplier, A<=0, q_m1<=0, count<=0, state<=CALC.
  - Otherwise the core stays in IDLE.
- CALC, one step per edge E1..EWIDTH:
  - {Qr[0],q_m1}=01: A+Mr.
  - =10: A-Mr.
  - =00 or 11: A unchanged.
  - Then arithmetic shift right of {A,Qr,q_m1} by 1, replicating the A MSB. count<=count+1.
  - At edge EWIDTH (count==WIDTH-1): product<={A[WIDTH-1:0],Qr} taken from the post-shift value, state<=DONE.
- DONE: lasts exactly one cycle.
  - done=1; product is valid.
  - Next edge: start=1 is accepted exactly as in IDLE (goes to CALC); otherwise state<=IDLE.
- Latency: start sampled at E0 -> done high in the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after start. With WIDTH=8: 9 clocks.
- start while busy=1 is ignored; no queuing, no restart.
- Operand inputs may change freely during CALC without effect; only the values at the accepting edge are used.
- product holds its last value through IDLE and the next CALC; it is updated only at completion.
- All 2*WIDTH product bits are exact for every operand pair, including (-2^(W-1))*(-2^(W-1)) = +2^(2W-2).
- Reset during CALC aborts the operation: no done pulse, product=0.
- start asserted in the same cycle rst deasserts: rst dominates while high; the first start sampled after release is honoured.

Test Plan:
- WIDTH=8, M=7, Q=3, start pulse -> busy high 8 cycles, then done=1 for 1 cycle, product=0x0015. Check 9-clock latency.
- M=-5 (0xFB), Q=6 -> product=0xFFE2 (-30); M=6, Q=-5 -> same result.
- Corner cases:
  - M=-128, Q=-128 -> product=0x4000 (+16384).
  - M=-128, Q=127 -> 0xC080 (-16256).
  - M=0, Q=-1 -> 0x0000.
- Start at cycle 3 of CALC with different operands -> ignored; first result is unaffected, exactly one done pulse. Operands changed mid-CALC also have no effect.
- Back-to-back: start asserted during DONE cycle with M=2, Q=-3 -> accepted; second done 9 clocks later, product=0xFFFA. product holds the prior value meanwhile.
- rst pulsed asynchronously (mid-clock) at step 4 -> busy, done, product go to 0 immediately; no done pulse follows. A new start after release yields a correct result.
